// File: rtl/id_inst_queue_if.sv
// Bundle between the Icache response, the ID flow-control signals and the decoder.
// The queue takes the slave side; whatever drives Icache and flow control takes master.
interface id_inst_queue_if #(
  parameter int DEPTH  = 4,
  parameter int INST_W = 32,
  parameter int PC_W   = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Handshake: an Icache word is offered only in a cycle with Icache_ready_i=1 and
  // is never re-offered. The decoder takes id_inst_o/id_pc_o in a cycle where
  // id_valid_o=1 and fc_stall_id_i=0; otherwise the same word is offered again.
  logic              Icache_ready_i;
  logic [INST_W-1:0] Icache_inst_i;
  logic [PC_W-1:0]   Icache_pc_i;
  logic              fc_stall_id_i;
  logic              fc_flush_id_i;
  logic              replay_i;
  logic              id_valid_o;
  logic [INST_W-1:0] id_inst_o;
  logic [PC_W-1:0]   id_pc_o;
  logic [CNT_W-1:0]  queue_count_o;
  logic              queue_full_o;
  logic              queue_afull_o;
  logic              overflow_o;

  modport master (
    output Icache_ready_i, Icache_inst_i, Icache_pc_i,
    output fc_stall_id_i, fc_flush_id_i, replay_i,
    input  id_valid_o, id_inst_o, id_pc_o,
    input  queue_count_o, queue_full_o, queue_afull_o, overflow_o
  );

  modport slave (
    input  Icache_ready_i, Icache_inst_i, Icache_pc_i,
    input  fc_stall_id_i, fc_flush_id_i, replay_i,
    output id_valid_o, id_inst_o, id_pc_o,
    output queue_count_o, queue_full_o, queue_afull_o, overflow_o
  );
endinterface

// File: rtl/id_inst_queue.sv
// Instruction queue between Icache responses and the ID decoder: buffers {pc, inst}
// while ID stalls, bypasses when empty, drops responses in a post-flush shadow.
module id_inst_queue #(
  parameter int                 DEPTH        = 4,
  parameter int                 INST_W       = 32,
  parameter int                 PC_W         = 32,
  parameter int                 AFULL_MARGIN = 1,
  parameter int                 FLUSH_DROP   = 1,
  parameter logic [INST_W-1:0]  NOP_INST     = INST_W'(32'h00000013)
) (
  input logic              clk,
  input logic              rst,
  id_inst_queue_if.slave   bus
);
  localparam int               PTR_W     = $clog2(DEPTH);
  localparam int               CNT_W     = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_LVL = CNT_W'(DEPTH - AFULL_MARGIN);
  localparam logic [2:0]       DROP_INIT = 3'(FLUSH_DROP);

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];

  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [2:0]       drop_cnt;
  logic             overflow;
  logic             full_q;
  logic             afull_q;

  logic             drop;
  logic             resp;
  logic             head_vld;
  logic             bypass;
  logic             out_vld;
  logic             consume;
  logic             deq;
  logic             wr_req;
  logic             wr_en;
  logic             ovf_set;
  logic             is_full;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] count_eff;

  always_comb begin
    drop      = bus.fc_flush_id_i | (drop_cnt != 3'd0);
    resp      = bus.Icache_ready_i & ~drop;
    head_vld  = (count != '0);
    bypass    = ~head_vld & resp;
    // rst gates the output so the decoder never sees a bypassed word during reset
    out_vld   = (head_vld | bypass) & ~bus.replay_i & ~bus.fc_flush_id_i & ~rst;
    consume   = out_vld & ~bus.fc_stall_id_i;
    deq       = consume & head_vld;
    wr_req    = resp & ~(bypass & consume);
    is_full   = (count == FULL_LVL);
    wr_en     = wr_req & (~is_full | deq);
    ovf_set   = wr_req & is_full & ~deq;
    count_nxt = count + CNT_W'(wr_en) - CNT_W'(deq);
    count_eff = bus.fc_flush_id_i ? '0 : count_nxt;
  end

  assign bus.id_valid_o    = out_vld;
  assign bus.id_inst_o     = !out_vld ? NOP_INST :
                             (head_vld ? inst_mem[rd_ptr] : bus.Icache_inst_i);
  assign bus.id_pc_o       = !out_vld ? '0 :
                             (head_vld ? pc_mem[rd_ptr] : bus.Icache_pc_i);
  assign bus.queue_count_o = count;
  assign bus.queue_full_o  = full_q;
  assign bus.queue_afull_o = afull_q;
  assign bus.overflow_o    = overflow;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      inst_mem[wr_ptr] <= bus.Icache_inst_i;
      pc_mem[wr_ptr]   <= bus.Icache_pc_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      drop_cnt <= 3'd0;
      overflow <= 1'b0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      // Flags track the count that will be visible next cycle, so they never lag it
      full_q  <= (count_eff == FULL_LVL);
      afull_q <= (count_eff >= AFULL_LVL);
      if (bus.fc_flush_id_i) begin
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        drop_cnt <= DROP_INIT;
      end else begin
        count <= count_nxt;
        if (wr_en)              wr_ptr   <= wr_ptr + PTR_W'(1);
        if (deq)                rd_ptr   <= rd_ptr + PTR_W'(1);
        if (drop_cnt != 3'd0)   drop_cnt <= drop_cnt - 3'd1;
        if (ovf_set)            overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_id_inst_queue.sv
// Directed bench for id_inst_queue: an expected queue of {pc, inst} words is filled by
// the stimulus and drained by a monitor whenever the decoder takes a word.
module tb_id_inst_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [63:0] exp_q[$];

  id_inst_queue_if #(.DEPTH(DEPTH), .INST_W(32), .PC_W(32)) bus ();

  id_inst_queue #(
    .DEPTH(DEPTH), .INST_W(32), .PC_W(32), .AFULL_MARGIN(1),
    .FLUSH_DROP(1), .NOP_INST(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  function automatic logic [31:0] mk(input logic [31:0] pc);
    return {16'hA5A5, pc[15:0]} ^ 32'h00000013;
  endfunction

  task automatic drv(input logic rdy, input logic [31:0] pc, input logic stall,
                     input logic rep, input logic fl);
    bus.Icache_ready_i = rdy;
    bus.Icache_pc_i    = pc;
    bus.Icache_inst_i  = mk(pc);
    bus.fc_stall_id_i  = stall;
    bus.replay_i       = rep;
    bus.fc_flush_id_i  = fl;
  endtask

  task automatic sb_push(input logic [31:0] pc);
    exp_q.push_back({pc, mk(pc)});
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: a word is taken when valid and not stalled
  always @(negedge clk) begin
    if (!rst && bus.id_valid_o === 1'b1 && bus.fc_stall_id_i === 1'b0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pc %0h inst %0h expected none", bus.id_pc_o, bus.id_inst_o);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({bus.id_pc_o, bus.id_inst_o} !== e) begin
          n_fail++;
          $display("FAIL sb_word: got %0h expected %0h", {bus.id_pc_o, bus.id_inst_o}, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    drv(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    look();
    chk("rst_valid", 64'(bus.id_valid_o), 64'd0);
    chk("rst_inst",  64'(bus.id_inst_o),  64'(NOP));
    chk("rst_pc",    64'(bus.id_pc_o),    64'd0);
    chk("rst_count", 64'(bus.queue_count_o), 64'd0);
    chk("rst_ovf",   64'(bus.overflow_o), 64'd0);
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    cyc();

    // zero-latency bypass
    drv(1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
    bus.Icache_inst_i = 32'h00500093;
    exp_q.push_back({32'h80, 32'h00500093});
    look();
    chk("byp_valid", 64'(bus.id_valid_o), 64'd1);
    chk("byp_inst",  64'(bus.id_inst_o),  64'h00500093);
    chk("byp_count", 64'(bus.queue_count_o), 64'd0);
    cyc();
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    look();
    chk("byp_count_after", 64'(bus.queue_count_o), 64'd0);
    chk("idle_inst", 64'(bus.id_inst_o), 64'(NOP));
    cyc();

    // stall while three responses arrive, then drain
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 32'h84 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
      sb_push(32'h84 + 32'(4 * i));
      look();
      chk("stall_count", 64'(bus.queue_count_o), 64'(i));
      chk("stall_head",  64'(bus.id_pc_o), 64'h84);
      chk("stall_valid", 64'(bus.id_valid_o), 64'd1);
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      look();
      chk("drain_count", 64'(bus.queue_count_o), 64'(3 - i));
      cyc();
    end
    look();
    chk("drain_empty", 64'(bus.queue_count_o), 64'd0);
    chk("drain_valid", 64'(bus.id_valid_o), 64'd0);
    cyc();

    // fill to full under stall, fifth word overflows
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 32'hA0 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
      if (i < 4) sb_push(32'hA0 + 32'(4 * i));
      look();
      chk("fill_count", 64'(bus.queue_count_o), 64'(i));
      chk("fill_afull", 64'(bus.queue_afull_o), (i >= 3) ? 64'd1 : 64'd0);
      chk("fill_full",  64'(bus.queue_full_o),  (i == 4) ? 64'd1 : 64'd0);
      chk("fill_ovf",   64'(bus.overflow_o), 64'd0);
      cyc();
    end
    // full with simultaneous dequeue accepts the write
    drv(1'b1, 32'hB4, 1'b0, 1'b0, 1'b0);
    sb_push(32'hB4);
    look();
    chk("ovf_set",   64'(bus.overflow_o), 64'd1);
    chk("full_flag", 64'(bus.queue_full_o), 64'd1);
    chk("full_head", 64'(bus.id_pc_o), 64'hA0);
    cyc();
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    look();
    chk("full_deq_write", 64'(bus.queue_count_o), 64'd4);
    cyc();
    for (int i = 0; i < 4; i++) begin
      look();
      chk("ovf_drain_count", 64'(bus.queue_count_o), 64'(3 - i));
      cyc();
    end
    look();
    chk("ovf_sticky", 64'(bus.overflow_o), 64'd1);
    chk("afull_clear", 64'(bus.queue_afull_o), 64'd0);
    cyc();

    // replay bubble, with and without stall
    drv(1'b1, 32'h90, 1'b1, 1'b0, 1'b0);
    sb_push(32'h90);
    look();
    cyc();
    drv(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    look();
    chk("stall_replay_valid", 64'(bus.id_valid_o), 64'd0);
    chk("stall_replay_count", 64'(bus.queue_count_o), 64'd1);
    cyc();
    drv(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    look();
    chk("replay_valid", 64'(bus.id_valid_o), 64'd0);
    chk("replay_inst",  64'(bus.id_inst_o), 64'(NOP));
    cyc();
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    look();
    chk("replay_again_pc", 64'(bus.id_pc_o), 64'h90);
    cyc();
    look();
    chk("replay_empty", 64'(bus.queue_count_o), 64'd0);
    cyc();

    // flush with two queued, then drop shadow
    drv(1'b1, 32'hC0, 1'b1, 1'b0, 1'b0);
    sb_push(32'hC0);
    cyc();
    drv(1'b1, 32'hC4, 1'b1, 1'b0, 1'b0);
    sb_push(32'hC4);
    cyc();
    drv(1'b1, 32'hC8, 1'b0, 1'b0, 1'b1);
    exp_q.delete();
    look();
    chk("flush_valid", 64'(bus.id_valid_o), 64'd0);
    chk("flush_count_before", 64'(bus.queue_count_o), 64'd2);
    cyc();
    drv(1'b1, 32'hCC, 1'b0, 1'b0, 1'b0);
    look();
    chk("flush_count", 64'(bus.queue_count_o), 64'd0);
    chk("shadow_valid", 64'(bus.id_valid_o), 64'd0);
    cyc();
    drv(1'b1, 32'hD0, 1'b0, 1'b0, 1'b0);
    sb_push(32'hD0);
    look();
    chk("post_shadow_valid", 64'(bus.id_valid_o), 64'd1);
    cyc();
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    look();
    chk("post_shadow_count", 64'(bus.queue_count_o), 64'd0);
    cyc();

    // asynchronous reset with three queued
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 32'hE0 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
      sb_push(32'hE0 + 32'(4 * i));
      cyc();
    end
    drv(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    look();
    chk("prereset_count", 64'(bus.queue_count_o), 64'd3);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_valid", 64'(bus.id_valid_o), 64'd0);
    chk("arst_inst",  64'(bus.id_inst_o), 64'(NOP));
    chk("arst_pc",    64'(bus.id_pc_o), 64'd0);
    chk("arst_count", 64'(bus.queue_count_o), 64'd0);
    chk("arst_ovf",   64'(bus.overflow_o), 64'd0);
    chk("arst_afull", 64'(bus.queue_afull_o), 64'd0);
    look();
    rst = 1'b0;
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc();
    look();
    chk("postrst_count", 64'(bus.queue_count_o), 64'd0);
    chk("postrst_valid", 64'(bus.id_valid_o), 64'd0);
    cyc();
    drv(1'b1, 32'hF0, 1'b0, 1'b0, 1'b0);
    sb_push(32'hF0);
    look();
    chk("postrst_bypass", 64'(bus.id_valid_o), 64'd1);
    cyc();
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    look();
    cyc();

    // final report
    chk("sb_leftover", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
